// File: rtl/load_store_unit.sv
// Multi-cycle load/store unit: steers byte lanes to a variable-latency data memory
// over a req/gnt/rvalid handshake, extends load data and flags bad or timed-out accesses.
module load_store_unit #(
  parameter int XLEN    = 32,
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_load_i,
  input  logic              req_store_i,
  input  logic [2:0]        req_func3_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [XLEN-1:0]   req_wdata_i,
  output logic              resp_valid_o,
  output logic [XLEN-1:0]   resp_rdata_o,
  output logic              resp_err_o,
  output logic              stall_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [XLEN-1:0]   mem_wdata_o,
  output logic [XLEN/8-1:0] mem_be_o,
  input  logic              mem_gnt_i,
  input  logic              mem_rvalid_i,
  input  logic [XLEN-1:0]   mem_rdata_i
);

  localparam int BYTES = XLEN / 8;
  localparam int OFF_W = $clog2(BYTES);
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [2:0] {S_IDLE, S_ERR, S_REQ, S_WAIT, S_DONE} state_t;

  state_t            state_q;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [OFF_W-1:0]  off_q, off_d, amask;
  logic [1:0]        size_q, size_d;
  logic              uns_q, store_q;
  logic              resp_valid_q, resp_err_q, mem_req_q, mem_we_q;
  logic [XLEN-1:0]   resp_rdata_q, mem_wdata_q, wdata_d, shifted, ext, load_d;
  logic [ADDR_W-1:0] mem_addr_q, addr_d;
  logic [BYTES-1:0]  mem_be_q, smask, be_d;
  logic              illegal, misaligned, to_hit;

  always_comb begin
    size_d  = req_func3_i[1:0];
    off_d   = req_addr_i[OFF_W-1:0];
    illegal = (req_load_i == req_store_i) || (req_func3_i == 3'b111) ||
              (req_store_i && req_func3_i[2]);
    if ((XLEN == 32) && ((size_d == 2'b11) || (req_func3_i == 3'b110))) illegal = 1'b1;
    case (size_d)
      2'b00:   begin smask = BYTES'(8'h01); amask = '0;        end
      2'b01:   begin smask = BYTES'(8'h03); amask = OFF_W'(1); end
      2'b10:   begin smask = BYTES'(8'h0F); amask = OFF_W'(3); end
      default: begin smask = BYTES'(8'hFF); amask = OFF_W'(7); end
    endcase
    misaligned = |(off_d & amask);
    be_d       = smask << off_d;
    wdata_d    = req_wdata_i << {off_d, 3'b000};
    addr_d     = {req_addr_i[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
  end

  // Bring the addressed lane down to bit 0, then sign- or zero-extend by access size.
  always_comb begin
    shifted = mem_rdata_i >> {off_q, 3'b000};
    case (size_q)
      2'b00:   ext = uns_q ? XLEN'(shifted[7:0])  : XLEN'($signed(shifted[7:0]));
      2'b01:   ext = uns_q ? XLEN'(shifted[15:0]) : XLEN'($signed(shifted[15:0]));
      2'b10:   ext = uns_q ? XLEN'(shifted[31:0]) : XLEN'($signed(shifted[31:0]));
      default: ext = shifted;
    endcase
    load_d = store_q ? '0 : ext;
    cnt_d  = cnt_q + CNT_W'(1);
    to_hit = (TIMEOUT != 0) && (cnt_d == CNT_W'(TIMEOUT));
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      off_q        <= '0;
      size_q       <= '0;
      uns_q        <= 1'b0;
      store_q      <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_be_q     <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          resp_valid_q <= 1'b0;
          resp_err_q   <= 1'b0;
          resp_rdata_q <= '0;
          cnt_q        <= '0;
          if (req_valid_i) begin
            off_q   <= off_d;
            size_q  <= size_d;
            uns_q   <= req_func3_i[2];
            store_q <= req_store_i;
            if (illegal || misaligned) begin
              state_q      <= S_ERR;
              resp_valid_q <= 1'b1;
              resp_err_q   <= 1'b1;
            end else begin
              state_q     <= S_REQ;
              mem_req_q   <= 1'b1;
              mem_we_q    <= req_store_i;
              mem_addr_q  <= addr_d;
              mem_be_q    <= be_d;
              mem_wdata_q <= wdata_d;
            end
          end
        end
        S_ERR: begin
          resp_valid_q <= 1'b0;
          resp_err_q   <= 1'b0;
          state_q      <= S_IDLE;
        end
        S_REQ: begin
          cnt_q <= cnt_d;
          if (to_hit) begin
            mem_req_q    <= 1'b0;
            state_q      <= S_DONE;
            resp_valid_q <= 1'b1;
            resp_err_q   <= 1'b1;
            resp_rdata_q <= '0;
          end else if (mem_gnt_i) begin
            mem_req_q <= 1'b0;
            state_q   <= S_WAIT;
          end
        end
        // A response arriving on the timeout cycle still counts as a normal completion.
        S_WAIT: begin
          cnt_q <= cnt_d;
          if (mem_rvalid_i) begin
            state_q      <= S_DONE;
            resp_valid_q <= 1'b1;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= load_d;
          end else if (to_hit) begin
            state_q      <= S_DONE;
            resp_valid_q <= 1'b1;
            resp_err_q   <= 1'b1;
            resp_rdata_q <= '0;
          end
        end
        default: begin
          resp_valid_q <= 1'b0;
          resp_err_q   <= 1'b0;
          resp_rdata_q <= '0;
          state_q      <= S_IDLE;
        end
      endcase
    end
  end

  assign req_ready_o  = (state_q == S_IDLE);
  assign resp_valid_o = resp_valid_q;
  assign resp_err_o   = resp_err_q;
  assign resp_rdata_o = resp_rdata_q;
  assign stall_o      = req_valid_i & ~resp_valid_q;
  assign mem_req_o    = mem_req_q;
  assign mem_we_o     = mem_we_q;
  assign mem_addr_o   = mem_addr_q;
  assign mem_wdata_o  = mem_wdata_q;
  assign mem_be_o     = mem_be_q;

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Parametrised multi-cycle load/store unit. Replaces the fixed single-cycle data memory and byte-lane wrapper pair in the next-generation core.
- Talks to a variable-latency data memory over a request/grant/response handshake.
- Performs byte-lane steering, write masking, load sign/zero extension, misalignment checks and timeout detection.
- Asserts a stall to the core until the access completes.

Parameters:
- XLEN, 32, data width in bits; legal values 32 or 64.
- ADDR_W, 32, byte address width.
- TIMEOUT, 16, maximum cycles spent in REQ+WAIT before abort; 0 disables the timeout.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req_valid  in  1  core requests an access; held high until the response
- req_ready  out  1  high when in IDLE; the request is accepted when req_valid & req_ready
- req_load  in  1  load operation
- req_store  in  1  store operation
- req_func3  in  3  RISC-V funct3 size/sign code
- req_addr  in  ADDR_W  byte address
- req_wdata  in  XLEN  store data, right-aligned
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  XLEN  extended load data; 0 for stores and errors
- resp_err  out  1  qualified by resp_valid; misaligned, illegal or timeout
- stall  out  1  req_valid & ~resp_valid (combinational)
- mem_req  out  1  memory request, held until mem_gnt
- mem_we  out  1  write enable
- mem_addr  out  ADDR_W  address aligned to XLEN/8 bytes (low bits zero)
- mem_wdata  out  XLEN  lane-shifted write data
- mem_be  out  XLEN/8  byte enables
- mem_gnt  in  1  memory accepted the request this cycle
- mem_rvalid  in  1  read data valid / write acknowledge
- mem_rdata  in  XLEN  full-width read word

Behaviour:
- Reset: state IDLE, timeout counter 0, resp_valid=0, resp_err=0, resp_rdata=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, mem_be=0. A reset asserted mid-access returns to IDLE on that edge and drops mem_req. A later mem_rvalid for the abandoned access is ignored.
- Accept: in IDLE with req_valid=1, register addr, func3, wdata and is_store. The offset is addr[log2(XLEN/8)-1:0].
- Size decode:
  - func3[1:0]: 00 = byte, 01 = half, 10 = word, 11 = double.
  - func3[2] = 1 means unsigned (LBU/LHU/LWU).
  - Illegal combinations:
    - size double when XLEN=32;
    - LWU when XLEN=32;
    - func3[2]=1 on a store;
    - func3=111;
    - req_load==req_store (both 0 or both 1).
- Misaligned: offset mod size != 0.
- States:
  - IDLE: on an illegal or misaligned request go to ERR; otherwise go to REQ.
  - ERR: one cycle; resp_valid=1, resp_err=1, no memory request issued; return to IDLE.
  - REQ: mem_req=1, with mem_addr, mem_we, mem_be and mem_wdata stable. On mem_gnt go to WAIT; mem_req drops the next cycle.
  - WAIT: on mem_rvalid, register the result; resp_valid=1 in the next cycle (DONE), then IDLE.
  - DONE: resp_valid=1 for exactly one cycle; req_ready=0; return to IDLE.
- Timeout: the counter increments every cycle in REQ or WAIT and clears in IDLE. When it reaches TIMEOUT, go to DONE with resp_err=1 and resp_rdata=0, and drop mem_req. If mem_rvalid arrives in the same cycle the counter reaches TIMEOUT, mem_rvalid wins and the response is a normal one.
- Latency: accepted at cycle N gives mem_req at N+1. Gnt at N+1 and rvalid at N+2 give resp_valid at N+3 (minimum). The error path gives resp_valid at N+1.
- Stores:
  - mem_be = size mask (1, 3, 0xF, 0xFF) << offset.
  - mem_wdata = wdata replicated/shifted so that byte i of the operand lands on lane offset+i.
  - mem_rvalid acts as the write acknowledge; resp_rdata=0.
- Loads:
  - mem_be = size mask << offset.
  - The result is (mem_rdata >> 8*offset), truncated to size, then sign-extended (func3[2]=0) or zero-extended to XLEN.
- Back-to-back: a new request can be accepted in the IDLE cycle following DONE or ERR; no bubble beyond that is required.
- resp_valid is never asserted two consecutive cycles.

Test Plan:
- XLEN=32, LW addr 0x100, gnt same cycle, rvalid next cycle with rdata 0xDEADBEEF -> mem_addr=0x100, mem_be=0xF, resp_valid at N+3, resp_rdata=0xDEADBEEF, resp_err=0.
- SB addr 0x203, wdata 0x000000A5 -> mem_addr=0x200, mem_be=0x8, mem_wdata[31:24]=0xA5; after the rvalid acknowledge, resp_valid=1, resp_err=0.
- LH addr 0x102 with rdata 0x8001_1234 -> resp_rdata=0xFFFF8001. LHU at the same address -> resp_rdata=0x00008001.
- LW addr 0x102 -> no mem_req ever, resp_valid at N+1 with resp_err=1. Also SD with XLEN=32 -> resp_err=1.
- TIMEOUT=4, memory never grants -> mem_req high for 4 cycles then low, resp_valid with resp_err=1 and resp_rdata=0. A late rvalid is ignored and stall releases.
- XLEN=64, LD addr 0x08 with rdata 0x0123456789ABCDEF -> mem_be=0xFF, exact data returned. Separately, rst asserted in WAIT -> next cycle IDLE, all outputs 0, and the following LW completes normally.
